sap_sequencer: RTL and testbench
================================

SAP_SEQUENCER -- requirements
Module: sap_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_W, default 4, meaning opcode width; legal values are 4 or greater, and opcode bits above [3:0] that are nonzero decode as NOP.
REQ-002 SHALL have parameter CW_W, default 16, meaning control-word width; it is fixed at 16 by the package and checked at elaboration.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port run_en  input  1  1 = advance stage each cycle, 0 = hold the current stage and keep driving its control word.
REQ-006 SHALL have port opcode  input  OPCODE_W  instruction register opcode field.
REQ-007 SHALL have ports flag_c and flag_z  input  1 each  ALU carry and zero flags from the flags register.
REQ-008 SHALL have port ctrl  output  CW_W  control word. Bit map: 15 HLT, 14 PC_INC, 13 PC_EN, 12 PC_LOAD, 11 MEM_LOAD, 10 RAM_EN, 9 RAM_WR, 8 IR_LOAD, 7 IR_EN, 6 A_LOAD, 5 A_EN, 4 B_LOAD, 3 ALU_SUB, 2 ALU_EN, 1 OUT_LOAD, 0 FLAGS_LOAD.
REQ-009 SHALL have port stage  output  3  current T-state, 0..5.
REQ-010 SHALL have port instr_done  output  1  high during the final stage of the current instruction.
REQ-011 SHALL have port halted  output  1  sticky halt indicator.

Function
REQ-012 SHALL derive ctrl and instr_done combinationally from stage, opcode and flags, so each word is valid for the whole stage.
REQ-013 Fetch SHALL use three stages for every opcode: T0 = PC_EN|MEM_LOAD; T1 = PC_INC; T2 = RAM_EN|IR_LOAD.
REQ-014 Execute stages SHALL be, with "last" marking the final stage:
- LDA (0): T3 IR_EN|MEM_LOAD; T4 RAM_EN|A_LOAD, last.
- ADD (1) and SUB (2): T3 IR_EN|MEM_LOAD; T4 RAM_EN|B_LOAD; T5 ALU_EN|A_LOAD|FLAGS_LOAD (SUB adds ALU_SUB), last.
REQ-015 Execute stages SHALL further be:
- STA (3): T3 IR_EN|MEM_LOAD; T4 A_EN|RAM_WR, last.
- LDI (4): T3 IR_EN|A_LOAD, last.
- JMP (5): T3 IR_EN|PC_LOAD, last.
- OUT (14): T3 A_EN|OUT_LOAD, last.
REQ-016 JC (6) and JZ (7) SHALL drive IR_EN|PC_LOAD at T3 only if flag_c or flag_z respectively is 1 during T3; otherwise T3 drives 0. In both cases T3 is last.
REQ-017 Undefined opcodes SHALL drive 0 at T3, and T3 is last (NOP, 4 cycles).
REQ-018 When run_en=1 and not halted, stage SHALL go to 0 after a last stage and to stage+1 otherwise; stage never exceeds 5.
REQ-019 HLT (15) SHALL drive HLT at T3 and set halted on that posedge; stage then freezes at 3 and ctrl stays at HLT only, until reset.
REQ-020 An opcode change mid-instruction SHALL take effect combinationally; the IR is stable after T2 by system contract.
REQ-021 When run_en=0 on the HLT T3 cycle, halted SHALL NOT set until run_en=1 on a posedge.

Reset
REQ-022 While rst=1: stage=0, halted=0, ctrl=0 and instr_done=0 (ctrl forced to 0 regardless of decode).
REQ-023 Reset asserted mid-instruction or while halted SHALL abort immediately; after deassertion the first cycle is T0 fetch.

Structure
REQ-024 Package sap_ctrl_pkg SHALL hold the opcode constants, control-bit index constants, CW_W and the stage type.
REQ-025 Decode SHALL live in the combinational sub-module sap_ucode_rom (inputs stage, opcode, flags; outputs ctrl and last); the state register and halt latch live in the top level.

Verification
REQ-026 Fixed opcodes LDA, ADD, HLT in sequence, run_en=1 -> instruction lengths 5, 6 and 4 cycles; halted=1 from cycle 16; ctrl=0x8000 held.
REQ-027 JC with flag_c=0 -> T3 ctrl=0x0000 and the next cycle is T0; with flag_c=1 -> T3 ctrl=0x1080.
REQ-028 SUB -> T5 ctrl=0x004D; STA -> T4 ctrl=0x0220; OUT -> T3 ctrl=0x0022.
REQ-029 run_en=0 held 3 cycles at ADD T4 -> stage stays 4 and ctrl=0x0410 throughout, then resumes to T5.
REQ-030 rst pulse at ADD T5 and while halted -> stage, halted and ctrl go to 0 asynchronously; after release, T0 ctrl=0x2800.
REQ-031 OPCODE_W=6 with opcode 0x11 -> NOP, 4 cycles, T3 ctrl=0.

Source files
------------

// File: rtl/sap_ctrl_pkg.sv
// Shared constants and types for the SAP-1 style control sequencer.
package sap_ctrl_pkg;

  localparam int CW_W = 16;

  // Opcode values carried in the low four bits of the IR opcode field.
  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDI = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JC  = 4'd6;
  localparam logic [3:0] OP_JZ  = 4'd7;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // Control-word bit positions.
  localparam int unsigned B_HLT        = 15;
  localparam int unsigned B_PC_INC     = 14;
  localparam int unsigned B_PC_EN      = 13;
  localparam int unsigned B_PC_LOAD    = 12;
  localparam int unsigned B_MEM_LOAD   = 11;
  localparam int unsigned B_RAM_EN     = 10;
  localparam int unsigned B_RAM_WR     = 9;
  localparam int unsigned B_IR_LOAD    = 8;
  localparam int unsigned B_IR_EN      = 7;
  localparam int unsigned B_A_LOAD     = 6;
  localparam int unsigned B_A_EN       = 5;
  localparam int unsigned B_B_LOAD     = 4;
  localparam int unsigned B_ALU_SUB    = 3;
  localparam int unsigned B_ALU_EN     = 2;
  localparam int unsigned B_OUT_LOAD   = 1;
  localparam int unsigned B_FLAGS_LOAD = 0;

  typedef logic [CW_W-1:0] cw_t;

  // T-states; values 6 and 7 are never reached.
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } stage_t;

  // One-hot control word with only bit idx set.
  function automatic cw_t cw_bit(input int unsigned idx);
    cw_bit = cw_t'(1) << idx;
  endfunction

endpackage

// File: rtl/sap_ucode_rom.sv
// Combinational microcode: maps (stage, opcode, flags) to a control word
// and marks the final stage of each instruction.
module sap_ucode_rom
  import sap_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  stage_t              stage,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_c,
  input  logic                flag_z,
  output cw_t                 ctrl,
  output logic                last
);

  // Any set bit above [3:0] turns the instruction into a NOP.
  logic       op_legal;
  logic [3:0] op4;

  assign op_legal = ((opcode >> 4) == '0);
  assign op4      = opcode[3:0];

  // Decode table: fetch is common, execute depends on opcode and flags.
  always_comb begin
    ctrl = '0;
    last = 1'b0;
    case (stage)
      T0: ctrl = cw_bit(B_PC_EN) | cw_bit(B_MEM_LOAD);
      T1: ctrl = cw_bit(B_PC_INC);
      T2: ctrl = cw_bit(B_RAM_EN) | cw_bit(B_IR_LOAD);
      T3: begin
        last = 1'b1;
        if (op_legal) begin
          case (op4)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl = cw_bit(B_IR_EN) | cw_bit(B_MEM_LOAD);
              last = 1'b0;
            end
            OP_LDI: ctrl = cw_bit(B_IR_EN) | cw_bit(B_A_LOAD);
            OP_JMP: ctrl = cw_bit(B_IR_EN) | cw_bit(B_PC_LOAD);
            OP_JC:  if (flag_c) ctrl = cw_bit(B_IR_EN) | cw_bit(B_PC_LOAD);
            OP_JZ:  if (flag_z) ctrl = cw_bit(B_IR_EN) | cw_bit(B_PC_LOAD);
            OP_OUT: ctrl = cw_bit(B_A_EN) | cw_bit(B_OUT_LOAD);
            OP_HLT: ctrl = cw_bit(B_HLT);
            default: ctrl = '0;
          endcase
        end
      end
      T4: begin
        last = 1'b1;
        if (op_legal) begin
          case (op4)
            OP_LDA: ctrl = cw_bit(B_RAM_EN) | cw_bit(B_A_LOAD);
            OP_ADD, OP_SUB: begin
              ctrl = cw_bit(B_RAM_EN) | cw_bit(B_B_LOAD);
              last = 1'b0;
            end
            OP_STA: ctrl = cw_bit(B_A_EN) | cw_bit(B_RAM_WR);
            default: ctrl = '0;
          endcase
        end
      end
      T5: begin
        last = 1'b1;
        if (op_legal && (op4 == OP_ADD || op4 == OP_SUB)) begin
          ctrl = cw_bit(B_ALU_EN) | cw_bit(B_A_LOAD) | cw_bit(B_FLAGS_LOAD);
          if (op4 == OP_SUB) ctrl = ctrl | cw_bit(B_ALU_SUB);
        end
      end
      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/sap_sequencer.sv
// SAP-1 control sequencer: T-state register, sticky halt latch and
// output gating around the microcode ROM.
module sap_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int CW_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_c,
  input  logic                flag_z,
  output logic [CW_W-1:0]     ctrl,
  output logic [2:0]          stage,
  output logic                instr_done,
  output logic                halted
);
  import sap_ctrl_pkg::*;

  if (CW_W != sap_ctrl_pkg::CW_W) begin : g_cw_check
    $fatal(1, "sap_sequencer: CW_W must be 16");
  end
  if (OPCODE_W < 4) begin : g_op_check
    $fatal(1, "sap_sequencer: OPCODE_W must be 4 or greater");
  end

  stage_t stage_q, stage_d;
  logic   halted_q, halted_d;
  cw_t    rom_ctrl;
  logic   rom_last;
  logic   halt_now;

  sap_ucode_rom #(
    .OPCODE_W(OPCODE_W)
  ) u_rom (
    .stage  (stage_q),
    .opcode (opcode),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .ctrl   (rom_ctrl),
    .last   (rom_last)
  );

  // Next stage and halt: halting freezes the stage at T3 on the HLT edge.
  always_comb begin
    stage_d  = stage_q;
    halted_d = halted_q;
    halt_now = run_en && !halted_q && rom_ctrl[B_HLT];
    if (halt_now) begin
      halted_d = 1'b1;
    end else if (run_en && !halted_q) begin
      stage_d = rom_last ? T0 : stage_t'(stage_q + 3'd1);
    end
  end

  // State register with asynchronous abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      halted_q <= halted_d;
    end
  end

  // Reset forces a quiet bus; a halted machine keeps asserting only HLT.
  always_comb begin
    ctrl       = '0;
    instr_done = 1'b0;
    if (!rst) begin
      if (halted_q) begin
        ctrl = cw_bit(B_HLT);
      end else begin
        ctrl       = rom_ctrl;
        instr_done = rom_last;
      end
    end
  end

  assign stage  = stage_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed bench for sap_sequencer with hand-computed control words.
module tb_sap_sequencer;

  localparam logic [3:0] LDA = 4'd0,  ADD = 4'd1,  SUB = 4'd2, STA = 4'd3;
  localparam logic [3:0] LDI = 4'd4,  JMP = 4'd5,  JC  = 4'd6, JZ  = 4'd7;
  localparam logic [3:0] UND = 4'd9,  OUT = 4'd14, HLT = 4'd15;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_en;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic [15:0] ctrl;
  logic [2:0]  stage;
  logic        instr_done;
  logic        halted;

  logic [5:0]  opcode6;
  logic [15:0] ctrl6;
  logic [2:0]  stage6;
  logic        done6;
  logic        halted6;

  int errors = 0;
  int checks = 0;

  sap_sequencer #(.OPCODE_W(4), .CW_W(16)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z), .ctrl(ctrl), .stage(stage),
    .instr_done(instr_done), .halted(halted)
  );

  sap_sequencer #(.OPCODE_W(6), .CW_W(16)) dut6 (
    .clk(clk), .rst(rst), .run_en(run_en), .opcode(opcode6),
    .flag_c(flag_c), .flag_z(flag_z), .ctrl(ctrl6), .stage(stage6),
    .instr_done(done6), .halted(halted6)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check one stage's outputs, then advance a cycle.
  task automatic cyc(input string tag, input int st, input logic [15:0] cw, input logic done);
    chk({tag, "/stage"}, 32'(stage), 32'(st));
    chk({tag, "/ctrl"}, 32'(ctrl), 32'(cw));
    chk({tag, "/done"}, 32'(instr_done), 32'(done));
    tick();
  endtask

  task automatic fetch(input string tag, input logic [3:0] op);
    opcode = op;
    #1;
    cyc({tag, "_T0"}, 0, 16'h2800, 1'b0);
    cyc({tag, "_T1"}, 1, 16'h4000, 1'b0);
    cyc({tag, "_T2"}, 2, 16'h0500, 1'b0);
  endtask

  // Asynchronous reset pulse mid-cycle; leaves the machine in T0.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "/rst_stage"}, 32'(stage), 32'd0);
    chk({tag, "/rst_halted"}, 32'(halted), 32'd0);
    chk({tag, "/rst_ctrl"}, 32'(ctrl), 32'h0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [2:0]  nop_st[5]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
  logic [15:0] nop_cw[5]  = '{16'h2800, 16'h4000, 16'h0500, 16'h0000, 16'h2800};
  logic        nop_dn[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; run_en = 1'b1; opcode = LDA; flag_c = 1'b0; flag_z = 1'b0;
    opcode6 = 6'h11;
    repeat (3) @(posedge clk);
    #2;
    chk("reset/stage", 32'(stage), 32'd0);
    chk("reset/halted", 32'(halted), 32'd0);
    chk("reset/ctrl", 32'(ctrl), 32'h0);
    chk("reset/done", 32'(instr_done), 32'd0);
    rst = 1'b0;
    #1;

    // LDA (5 cycles), ADD (6 cycles), HLT (4 cycles), then halted.
    fetch("lda", LDA);
    cyc("lda_T3", 3, 16'h0880, 1'b0);
    cyc("lda_T4", 4, 16'h0440, 1'b1);
    fetch("add", ADD);
    cyc("add_T3", 3, 16'h0880, 1'b0);
    cyc("add_T4", 4, 16'h0410, 1'b0);
    cyc("add_T5", 5, 16'h0045, 1'b1);
    fetch("hlt", HLT);
    chk("hlt_T3/halted_pre", 32'(halted), 32'd0);
    cyc("hlt_T3", 3, 16'h8000, 1'b1);
    opcode = LDA;
    for (int i = 0; i < 3; i++) begin
      chk("halted/flag", 32'(halted), 32'd1);
      chk("halted/stage", 32'(stage), 32'd3);
      chk("halted/ctrl", 32'(ctrl), 32'h8000);
      tick();
    end
    do_reset("rst_halted");

    // SUB, STA, OUT, LDI, JMP
    fetch("sub", SUB);
    cyc("sub_T3", 3, 16'h0880, 1'b0);
    cyc("sub_T4", 4, 16'h0410, 1'b0);
    cyc("sub_T5", 5, 16'h004D, 1'b1);
    fetch("sta", STA);
    cyc("sta_T3", 3, 16'h0880, 1'b0);
    cyc("sta_T4", 4, 16'h0220, 1'b1);
    fetch("out", OUT);
    cyc("out_T3", 3, 16'h0022, 1'b1);
    fetch("ldi", LDI);
    cyc("ldi_T3", 3, 16'h00C0, 1'b1);
    fetch("jmp", JMP);
    cyc("jmp_T3", 3, 16'h1080, 1'b1);

    // Conditional jumps: each must look only at its own flag.
    fetch("jc0", JC);
    flag_c = 1'b0; flag_z = 1'b1; #1;
    cyc("jc0_T3", 3, 16'h0000, 1'b1);
    fetch("jc1", JC);
    flag_c = 1'b1; flag_z = 1'b0; #1;
    cyc("jc1_T3", 3, 16'h1080, 1'b1);
    fetch("jz0", JZ);
    flag_c = 1'b1; flag_z = 1'b0; #1;
    cyc("jz0_T3", 3, 16'h0000, 1'b1);
    fetch("jz1", JZ);
    flag_c = 1'b0; flag_z = 1'b1; #1;
    cyc("jz1_T3", 3, 16'h1080, 1'b1);
    flag_c = 1'b0; flag_z = 1'b0;

    // Undefined opcode is a 4-cycle NOP.
    fetch("und", UND);
    cyc("und_T3", 3, 16'h0000, 1'b1);

    // Stall at ADD T4 for three cycles.
    fetch("stall", ADD);
    cyc("stall_T3", 3, 16'h0880, 1'b0);
    run_en = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_T4/stage", 32'(stage), 32'd4);
      chk("stall_T4/ctrl", 32'(ctrl), 32'h0410);
      if (i < 3) tick();
    end
    run_en = 1'b1;
    tick();
    cyc("stall_T5", 5, 16'h0045, 1'b1);

    // HLT at T3 with run_en low must not latch until run_en returns.
    fetch("hltw", HLT);
    run_en = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("hltw_wait/halted", 32'(halted), 32'd0);
      chk("hltw_wait/stage", 32'(stage), 32'd3);
      chk("hltw_wait/ctrl", 32'(ctrl), 32'h8000);
      tick();
    end
    run_en = 1'b1;
    tick();
    chk("hltw_go/halted", 32'(halted), 32'd1);
    chk("hltw_go/stage", 32'(stage), 32'd3);
    do_reset("rst_hltw");

    // Reset at ADD T5 aborts asynchronously; next cycle is T0 fetch.
    fetch("abort", ADD);
    cyc("abort_T3", 3, 16'h0880, 1'b0);
    cyc("abort_T4", 4, 16'h0410, 1'b0);
    chk("abort_T5/ctrl", 32'(ctrl), 32'h0045);
    rst = 1'b1;
    #1;
    chk("abort_rst/stage", 32'(stage), 32'd0);
    chk("abort_rst/ctrl", 32'(ctrl), 32'h0);
    chk("abort_rst/halted", 32'(halted), 32'd0);
    chk("abort_rst/done", 32'(instr_done), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    cyc("abort_T0", 0, 16'h2800, 1'b0);

    // Wide opcode with upper bits set decodes as NOP.
    do_reset("rst_w6");
    for (int i = 0; i < 5; i++) begin
      chk("w6/stage", 32'(stage6), 32'(nop_st[i]));
      chk("w6/ctrl", 32'(ctrl6), 32'(nop_cw[i]));
      chk("w6/done", 32'(done6), 32'(nop_dn[i]));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
